// File: rtl/fp_agg_pkg.sv
// Shared types and constants for the FP aggregation scheduler.
//   state_e        : scheduler FSM states
//   NUM_LANES      : number of operand lanes feeding the adder tree
//   FP_ZERO        : +0.0 in IEEE-754 single, used for masked lanes
//   credit_width() : width needed to hold 0..depth credits
package fp_agg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned NUM_LANES = 4;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fp_agg_credit_ctr.sv
// Saturating credit counter tracking free result-FIFO slots.
//   aclk, srst    : clock, synchronous active-high reset (restores full credit)
//   consume_i     : one operand set issued into the tree
//   return_i      : one result popped from the FIFO
//   credits_o     : current free-slot count, 0..FIFO_DEPTH
//   has_credit_o  : at least one free slot
module fp_agg_credit_ctr
  import fp_agg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                    aclk,
  input  logic                                    srst,
  input  logic                                    consume_i,
  input  logic                                    return_i,
  output logic [credit_width(FIFO_DEPTH)-1:0]     credits_o,
  output logic                                    has_credit_o
);

  localparam int unsigned CW = credit_width(FIFO_DEPTH);
  localparam logic [CW-1:0] MaxCred = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] One     = CW'(1);

  logic [CW-1:0] credits_q, credits_d;

  // Simultaneous consume and return cancel out.
  always_comb begin
    credits_d = credits_q;
    if (consume_i && !return_i) begin
      if (credits_q != '0) credits_d = credits_q - One;
    end else if (return_i && !consume_i) begin
      if (credits_q < MaxCred) credits_d = credits_q + One;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) credits_q <= MaxCred;
    else      credits_q <= credits_d;
  end

  assign credits_o    = credits_q;
  assign has_credit_o = (credits_q != '0);

endmodule

// File: rtl/fp_agg_scheduler.sv
// Issue controller for the 4-input FP adder tree and its result FIFO.
// Waits until every enabled lane is valid and a FIFO credit is free, then
// launches one aligned operand set per cycle for cfg_num_elems beats, then
// waits out the tree latency before pulsing done.
//   aclk, srst              : clock, synchronous active-high reset
//   cfg_start/num_elems/mask: job configuration, sampled in idle
//   S_AXIS_n_*              : per-lane AXI-Stream operand inputs
//   tree_in_n_tdata/valid   : registered operand set to the adder tree
//   fifo_rd_en/fifo_empty   : result FIFO pop observation for credit return
//   busy, done, credits     : status
module fp_agg_scheduler
  import fp_agg_pkg::*;
#(
  parameter int unsigned FP_DATA_WIDTH = 32,
  parameter int unsigned TREE_LATENCY  = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                                aclk,
  input  logic                                srst,
  input  logic                                cfg_start,
  input  logic [CNT_WIDTH-1:0]                cfg_num_elems,
  input  logic [3:0]                          cfg_lane_mask,
  input  logic [FP_DATA_WIDTH-1:0]            S_AXIS_0_tdata,
  input  logic                                S_AXIS_0_tvalid,
  output logic                                S_AXIS_0_tready,
  input  logic [FP_DATA_WIDTH-1:0]            S_AXIS_1_tdata,
  input  logic                                S_AXIS_1_tvalid,
  output logic                                S_AXIS_1_tready,
  input  logic [FP_DATA_WIDTH-1:0]            S_AXIS_2_tdata,
  input  logic                                S_AXIS_2_tvalid,
  output logic                                S_AXIS_2_tready,
  input  logic [FP_DATA_WIDTH-1:0]            S_AXIS_3_tdata,
  input  logic                                S_AXIS_3_tvalid,
  output logic                                S_AXIS_3_tready,
  output logic [FP_DATA_WIDTH-1:0]            tree_in_0_tdata,
  output logic [FP_DATA_WIDTH-1:0]            tree_in_1_tdata,
  output logic [FP_DATA_WIDTH-1:0]            tree_in_2_tdata,
  output logic [FP_DATA_WIDTH-1:0]            tree_in_3_tdata,
  output logic                                tree_valid,
  input  logic                                fifo_rd_en,
  input  logic                                fifo_empty,
  output logic                                busy,
  output logic                                done,
  output logic [credit_width(FIFO_DEPTH)-1:0] credits
);

  localparam int unsigned DrainW = (TREE_LATENCY > 0) ? $clog2(TREE_LATENCY + 1) : 1;
  localparam logic [FP_DATA_WIDTH-1:0] Zero = FP_DATA_WIDTH'(FP_ZERO);

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DrainW-1:0]      drain_q, drain_d;
  logic                   tree_valid_q, tree_valid_d;
  logic [FP_DATA_WIDTH-1:0] tree_data_q [NUM_LANES];
  logic [FP_DATA_WIDTH-1:0] tree_data_d [NUM_LANES];

  logic [FP_DATA_WIDTH-1:0] lane_data [NUM_LANES];
  logic [NUM_LANES-1:0]     lane_valid;
  logic [NUM_LANES-1:0]     lane_ready;
  logic                     lanes_ok;
  logic                     has_credit;
  logic                     fire;

  assign lane_data[0] = S_AXIS_0_tdata;
  assign lane_data[1] = S_AXIS_1_tdata;
  assign lane_data[2] = S_AXIS_2_tdata;
  assign lane_data[3] = S_AXIS_3_tdata;
  assign lane_valid   = {S_AXIS_3_tvalid, S_AXIS_2_tvalid, S_AXIS_1_tvalid, S_AXIS_0_tvalid};

  fp_agg_credit_ctr #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit_ctr (
    .aclk         (aclk),
    .srst         (srst),
    .consume_i    (fire),
    .return_i     (fifo_rd_en & ~fifo_empty),
    .credits_o    (credits),
    .has_credit_o (has_credit)
  );

  // Barrier: disabled lanes never hold up a beat.
  always_comb begin
    lanes_ok = 1'b1;
    for (int unsigned n = 0; n < NUM_LANES; n++) begin
      if (mask_q[n] && !lane_valid[n]) lanes_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    fire    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          mask_d  = cfg_lane_mask;
          num_d   = cfg_num_elems;
          cnt_d   = '0;
          state_d = (cfg_num_elems == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (lanes_ok && has_credit) begin
          fire  = 1'b1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          // num_q is non-zero here, so num_q - 1 cannot wrap.
          if (cnt_q == num_q - CNT_WIDTH'(1)) begin
            drain_d = DrainW'(TREE_LATENCY);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) state_d = StDone;
        else               drain_d = drain_q - DrainW'(1);
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Operand registers only load on a fire; masked lanes issue +0.0.
  always_comb begin
    tree_valid_d = fire;
    lane_ready   = fire ? mask_q : '0;
    for (int unsigned n = 0; n < NUM_LANES; n++) begin
      tree_data_d[n] = tree_data_q[n];
      if (fire) tree_data_d[n] = mask_q[n] ? lane_data[n] : Zero;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= '0;
      tree_valid_q <= 1'b0;
      for (int unsigned n = 0; n < NUM_LANES; n++) tree_data_q[n] <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      tree_valid_q <= tree_valid_d;
      for (int unsigned n = 0; n < NUM_LANES; n++) tree_data_q[n] <= tree_data_d[n];
    end
  end

  assign S_AXIS_0_tready = lane_ready[0];
  assign S_AXIS_1_tready = lane_ready[1];
  assign S_AXIS_2_tready = lane_ready[2];
  assign S_AXIS_3_tready = lane_ready[3];
  assign tree_in_0_tdata = tree_data_q[0];
  assign tree_in_1_tdata = tree_data_q[1];
  assign tree_in_2_tdata = tree_data_q[2];
  assign tree_in_3_tdata = tree_data_q[3];
  assign tree_valid      = tree_valid_q;
  assign busy            = (state_q == StRun) || (state_q == StDrain);
  assign done            = (state_q == StDone);

endmodule

// File: tb/tb_fp_agg_scheduler.sv
// Directed self-checking bench for fp_agg_scheduler (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Cycle 0 is the cycle in which cfg_start is driven.
module tb_fp_agg_scheduler;

  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;

  logic        aclk = 1'b0;
  logic        srst;
  logic        cfg_start;
  logic [15:0] cfg_num_elems;
  logic [3:0]  cfg_lane_mask;
  logic [31:0] s_tdata  [4];
  logic        s_tvalid [4];
  logic [3:0]  rdy;
  logic [31:0] t0, t1, t2, t3;
  logic        tree_valid;
  logic        fifo_rd_en, fifo_empty;
  logic        busy, done;
  logic [4:0]  credits;

  always #5 aclk = ~aclk;

  fp_agg_scheduler dut (
    .aclk            (aclk),
    .srst            (srst),
    .cfg_start       (cfg_start),
    .cfg_num_elems   (cfg_num_elems),
    .cfg_lane_mask   (cfg_lane_mask),
    .S_AXIS_0_tdata  (s_tdata[0]),
    .S_AXIS_0_tvalid (s_tvalid[0]),
    .S_AXIS_0_tready (rdy[0]),
    .S_AXIS_1_tdata  (s_tdata[1]),
    .S_AXIS_1_tvalid (s_tvalid[1]),
    .S_AXIS_1_tready (rdy[1]),
    .S_AXIS_2_tdata  (s_tdata[2]),
    .S_AXIS_2_tvalid (s_tvalid[2]),
    .S_AXIS_2_tready (rdy[2]),
    .S_AXIS_3_tdata  (s_tdata[3]),
    .S_AXIS_3_tvalid (s_tvalid[3]),
    .S_AXIS_3_tready (rdy[3]),
    .tree_in_0_tdata (t0),
    .tree_in_1_tdata (t1),
    .tree_in_2_tdata (t2),
    .tree_in_3_tdata (t3),
    .tree_valid      (tree_valid),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_empty      (fifo_empty),
    .busy            (busy),
    .done            (done),
    .credits         (credits)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-job observation counters.
  int ready_cnt, tv_cnt, first_ready, first_tv, done_cyc, done_cnt, bad23, nz23;

  task automatic clr_mon();
    ready_cnt = 0; tv_cnt = 0; first_ready = -1; first_tv = -1;
    done_cyc = -1; done_cnt = 0; bad23 = 0; nz23 = 0;
  endtask

  task automatic mon(input int c);
    if (rdy != 4'b0000) begin
      ready_cnt++;
      if (first_ready < 0) first_ready = c;
    end
    if (rdy[3:2] != 2'b00) bad23++;
    if (tree_valid) begin
      tv_cnt++;
      if (first_tv < 0) first_tv = c;
      if ((t2 | t3) != 32'h0) nz23++;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = c;
    end
  endtask

  task automatic set_lanes(input logic [3:0] v, input logic [31:0] d0, d1, d2, d3);
    s_tvalid[0] = v[0]; s_tvalid[1] = v[1]; s_tvalid[2] = v[2]; s_tvalid[3] = v[3];
    s_tdata[0] = d0; s_tdata[1] = d1; s_tdata[2] = d2; s_tdata[3] = d3;
  endtask

  task automatic start_job(input logic [15:0] num, input logic [3:0] mask);
    @(negedge aclk);
    cfg_start     = 1'b1;
    cfg_num_elems = num;
    cfg_lane_mask = mask;
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      fifo_rd_en = 1'b1;
      fifo_empty = 1'b0;
    end
    @(negedge aclk);
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; cfg_start = 1'b0; cfg_num_elems = '0; cfg_lane_mask = '0;
    fifo_rd_en = 1'b0; fifo_empty = 1'b1;
    set_lanes(4'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset values
    repeat (2) @(negedge aclk);
    #1;
    check("rst_tready", {28'h0, rdy}, 64'h0);
    check("rst_tree_valid", {63'h0, tree_valid}, 64'h0);
    check("rst_tdata0", {32'h0, t0}, 64'h0);
    check("rst_busy_done", {62'h0, busy, done}, 64'h0);
    check("rst_credits", {59'h0, credits}, 64'd16);
    @(negedge aclk);
    srst = 1'b0;

    // Basic job: 3 beats, all lanes
    set_lanes(4'hF, F1, F2, F3, F4);
    clr_mon();
    start_job(16'd3, 4'hF);
    for (int c = 1; c <= 14; c++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      #1;
      mon(c);
      if (c == 1) check("basic_busy_s1", {63'h0, busy}, 64'h1);
      if (c == 2) begin
        check("basic_t0", {32'h0, t0}, {32'h0, F1});
        check("basic_t1", {32'h0, t1}, {32'h0, F2});
        check("basic_t2", {32'h0, t2}, {32'h0, F3});
        check("basic_t3", {32'h0, t3}, {32'h0, F4});
      end
      if (c == 13) check("basic_busy_at_done", {63'h0, busy}, 64'h0);
    end
    check("basic_fires", ready_cnt, 3);
    check("basic_first_fire", first_ready, 1);
    check("basic_tv_cnt", tv_cnt, 3);
    check("basic_first_tv", first_tv, 2);
    check("basic_done_cyc", done_cyc, 13);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_credits", {59'h0, credits}, 64'd13);
    pop(3);
    check("basic_credits_back", {59'h0, credits}, 64'd16);

    // Barrier: lane 2 invalid for cycles 1..5
    clr_mon();
    set_lanes(4'hB, F1, F2, F3, F4);
    start_job(16'd2, 4'hF);
    for (int c = 1; c <= 18; c++) begin
      @(negedge aclk);
      cfg_start   = 1'b0;
      s_tvalid[2] = (c >= 6);
      #1;
      mon(c);
    end
    check("barrier_first_fire", first_ready, 6);
    check("barrier_first_tv", first_tv, 7);
    check("barrier_fires", ready_cnt, 2);
    check("barrier_done_cyc", done_cyc, 17);
    pop(2);

    // Masking: only lanes 0/1 enabled, lanes 2/3 idle with junk data
    clr_mon();
    set_lanes(4'h3, F1, F2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    start_job(16'd2, 4'b0011);
    for (int c = 1; c <= 13; c++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      #1;
      mon(c);
      if (c == 1) check("mask_tready", {60'h0, rdy}, 64'h3);
      if (c == 2) check("mask_t1", {32'h0, t1}, {32'h0, F2});
    end
    check("mask_fires", ready_cnt, 2);
    check("mask_tready23", bad23, 0);
    check("mask_zero23", nz23, 0);
    check("mask_done_cyc", done_cyc, 12);
    pop(2);

    // Credit exhaustion: 20 beats, pops on cycles 21..24
    clr_mon();
    set_lanes(4'hF, F1, F2, F3, F4);
    start_job(16'd20, 4'hF);
    for (int c = 1; c <= 40; c++) begin
      @(negedge aclk);
      cfg_start  = 1'b0;
      fifo_rd_en = (c >= 21 && c <= 24);
      fifo_empty = !(c >= 21 && c <= 24);
      #1;
      mon(c);
      if (c == 20) begin
        check("cred_fires_at_stall", ready_cnt, 16);
        check("cred_zero", {59'h0, credits}, 64'd0);
        check("cred_stall_tready", {60'h0, rdy}, 64'h0);
      end
      if (c >= 23 && c <= 25) check("cred_fire_and_pop", {59'h0, credits}, 64'd1);
    end
    check("cred_total_fires", ready_cnt, 20);
    check("cred_done_cyc", done_cyc, 35);
    check("cred_final", {59'h0, credits}, 64'd0);
    pop(16);
    check("cred_restored", {59'h0, credits}, 64'd16);

    // Zero-length job
    clr_mon();
    start_job(16'd0, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      #1;
      mon(c);
      if (c == 1) check("zero_done_busy", {62'h0, done, busy}, 64'h2);
      if (c == 2) check("zero_done_clear", {63'h0, done}, 64'h0);
    end
    check("zero_no_fire", ready_cnt, 0);
    check("zero_no_tv", tv_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Start during RUN is ignored
    clr_mon();
    start_job(16'd3, 4'hF);
    for (int c = 1; c <= 14; c++) begin
      @(negedge aclk);
      cfg_start     = (c == 2);
      cfg_num_elems = (c == 2) ? 16'd100 : 16'd3;
      #1;
      mon(c);
    end
    check("restart_fires", ready_cnt, 3);
    check("restart_done_cyc", done_cyc, 13);
    check("restart_done_cnt", done_cnt, 1);
    pop(3);

    // Reset mid-RUN
    clr_mon();
    start_job(16'd10, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      srst      = (c == 4);
      #1;
      mon(c);
    end
    @(negedge aclk);
    srst = 1'b0;
    #1;
    check("srst_tready", {60'h0, rdy}, 64'h0);
    check("srst_tree_valid", {63'h0, tree_valid}, 64'h0);
    check("srst_tdata0", {32'h0, t0}, 64'h0);
    check("srst_busy_done", {62'h0, busy, done}, 64'h0);
    check("srst_credits", {59'h0, credits}, 64'd16);

    // Clean job after reset
    clr_mon();
    set_lanes(4'hF, F5, F2, F3, F4);
    start_job(16'd1, 4'hF);
    for (int c = 1; c <= 12; c++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      #1;
      mon(c);
      if (c == 2) check("post_srst_t0", {32'h0, t0}, {32'h0, F5});
    end
    check("post_srst_fires", ready_cnt, 1);
    check("post_srst_done_cyc", done_cyc, 11);
    check("post_srst_credits", {59'h0, credits}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
